serial_adder_ctrl: RTL

Sequencer that computes a W-bit addition by passing one bit pair per cycle through a single shared 1-bit full-adder cell, with a registered carry between bits. It accepts operand pairs on a valid/ready input channel and returns sum and carry-out on a valid/ready output channel. It is the area-minimal alternative to a W-bit parallel adder in the team's arithmetic library.

---
 rtl/serial_adder_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: W-bit adder that streams one bit pair per cycle through
// a single shared full-adder cell. The carry is registered between bits.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   io_in_*       operand channel (valid/ready); a, b are W bits, cin is bit-0 carry
//   io_out_*      result channel (valid/ready); sum is (a+b+cin) mod 2^W, cout is
//                 the carry out of bit W-1
//   io_busy       high while an operation is running or its result is pending
//
// Every output is decoded from registers, so there is no combinational path
// from any input to any output.

// 1-bit full-adder cell shared by all bit positions.
module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder_ctrl #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         io_in_valid,
    output logic         io_in_ready,
    input  logic [W-1:0] io_in_a,
    input  logic [W-1:0] io_in_b,
    input  logic         io_in_cin,
    output logic         io_out_valid,
    input  logic         io_out_ready,
    output logic [W-1:0] io_out_sum,
    output logic         io_out_cout,
    output logic         io_busy
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  a_sh, b_sh, sum_sh, sum_nxt;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          s_bit, c_bit;
    logic          accept, last_bit;

    assign accept   = io_in_valid && (state == IDLE);
    assign last_bit = (cnt == CW'(W - 1));

    serial_adder_fa u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (s_bit),
        .co (c_bit)
    );

    // New sum bit enters at the MSB; after W shifts bit 0 has reached the LSB.
    if (W == 1) begin : g_sum_w1
        assign sum_nxt = s_bit;
    end else begin : g_sum_wn
        assign sum_nxt = {s_bit, sum_sh[W-1:1]};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)       state_nxt = RUN;
            RUN:     if (last_bit)     state_nxt = DONE;
            DONE:    if (io_out_ready) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Datapath. Result registers are left alone in IDLE/DONE so the result
    // holds under backpressure and input activity outside IDLE is ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh   <= io_in_a;
                        b_sh   <= io_in_b;
                        carry  <= io_in_cin;
                        sum_sh <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    sum_sh <= sum_nxt;
                    carry  <= c_bit;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    // Wrap on the last bit; keeps a 1-bit counter at 0 when W=1.
                    cnt    <= last_bit ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign io_in_ready  = (state == IDLE);
    assign io_out_valid = (state == DONE);
    assign io_busy      = (state != IDLE);
    assign io_out_sum   = sum_sh;
    assign io_out_cout  = carry;

endmodule
